immed_gen_pipe: RTL

- Parametrised, pipelined immediate generator for the OTTER 5-stage decode stage.
- Extracts and extends the immediate for every RV32I/RV64I immediate format, plus Zicsr CSR-address and zimm fields.
- Registers its results through 1 or 2 stages with stall and flush control.
- Flags illegal or unsupported opcodes and keeps a saturating count of them for debug.

---
 rtl/immed_gen_pipe.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/immed_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator for the decode stage: extracts and
// extends immediates, flags illegal opcodes and counts them for debug.
module immed_gen_pipe #(
  parameter int          XLEN        = 32,
  parameter int          STAGES      = 1,
  parameter bit          ZICSR_EN    = 1'b1,
  parameter logic [31:0] DEFAULT_IMM = 32'hDEADBEEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INSTRUCT,
  input  logic            STALL,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  output logic [XLEN-1:0] IMM,
  output logic [2:0]      IMM_TYPE,
  output logic            ILLEGAL,
  output logic [15:0]     ILL_COUNT
);

  // Handshake: an instruction is accepted on an edge where IN_VALID && IN_READY;
  // IN_READY is simply !STALL, and FLUSH drops whatever is presented that cycle.

  localparam logic [2:0] T_I    = 3'd0;
  localparam logic [2:0] T_S    = 3'd1;
  localparam logic [2:0] T_B    = 3'd2;
  localparam logic [2:0] T_U    = 3'd3;
  localparam logic [2:0] T_J    = 3'd4;
  localparam logic [2:0] T_Z    = 3'd5;
  localparam logic [2:0] T_C    = 3'd6;
  localparam logic [2:0] T_NONE = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [31:0] dec_instr;
  logic        dec_valid;

  assign IN_READY = !STALL;

  generate
    if (STAGES == 2) begin : g_two
      logic [31:0] s1_instr_q;
      logic        s1_valid_q;
      logic        s1_valid_d;

      always_comb begin
        s1_valid_d = s1_valid_q;
        if (FLUSH)       s1_valid_d = 1'b0;
        else if (!STALL) s1_valid_d = IN_VALID;
      end

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          s1_valid_q <= 1'b0;
          s1_instr_q <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          if (!STALL && !FLUSH && IN_VALID) s1_instr_q <= INSTRUCT;
        end
      end

      assign dec_instr = s1_instr_q;
      assign dec_valid = s1_valid_q;
    end else begin : g_one
      assign dec_instr = INSTRUCT;
      assign dec_valid = IN_VALID;
    end
  endgenerate

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_d;
  logic [2:0]      type_d;
  logic            illegal_d;

  assign opcode = dec_instr[6:0];
  assign funct3 = dec_instr[14:12];

  // Every listed opcode ends in 2'b11, so a bad low pair falls into default.
  always_comb begin
    imm_d     = XLEN'(DEFAULT_IMM);
    type_d    = T_NONE;
    illegal_d = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_d  = XLEN'($signed(dec_instr[31:20]));
        type_d = T_I;
      end
      OP_STORE: begin
        imm_d  = XLEN'($signed({dec_instr[31:25], dec_instr[11:7]}));
        type_d = T_S;
      end
      OP_BRANCH: begin
        imm_d  = XLEN'($signed({dec_instr[31], dec_instr[7], dec_instr[30:25],
                                dec_instr[11:8], 1'b0}));
        type_d = T_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm_d  = XLEN'($signed({dec_instr[31:12], 12'b0}));
        type_d = T_U;
      end
      OP_JAL: begin
        imm_d  = XLEN'($signed({dec_instr[31], dec_instr[19:12], dec_instr[20],
                                dec_instr[30:21], 1'b0}));
        type_d = T_J;
      end
      OP_SYSTEM: begin
        if (ZICSR_EN) begin
          if (funct3[2]) begin
            imm_d  = XLEN'(dec_instr[19:15]);
            type_d = T_Z;
          end else if (funct3 != 3'b000) begin
            imm_d  = XLEN'(dec_instr[31:20]);
            type_d = T_C;
          end
        end
      end
      OP_REG, OP_FENCE: begin
        type_d = T_NONE;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  logic            out_valid_q;
  logic            out_valid_d;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      type_q;
  logic            illegal_q;
  logic [15:0]     ill_count_q;
  logic            load_out;
  logic            ill_inc;

  always_comb begin
    out_valid_d = out_valid_q;
    if (FLUSH)       out_valid_d = 1'b0;
    else if (!STALL) out_valid_d = dec_valid;
  end

  assign load_out = !STALL && !FLUSH && dec_valid;
  assign ill_inc  = load_out && illegal_d && (ill_count_q != 16'hFFFF);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      type_q      <= T_NONE;
      illegal_q   <= 1'b0;
      ill_count_q <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load_out) begin
        imm_q     <= imm_d;
        type_q    <= type_d;
        illegal_q <= illegal_d;
      end
      if (ill_inc) ill_count_q <= ill_count_q + 16'd1;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign IMM       = imm_q;
  assign IMM_TYPE  = type_q;
  assign ILLEGAL   = illegal_q;
  assign ILL_COUNT = ill_count_q;

endmodule
